// File: rtl/mmio_uart_tx_pkg.sv
// Shared definitions for the MMIO UART transmitter: FSM state type, status
// word bit positions and the payload width used by the transmit FIFO.
package mmio_uart_tx_pkg;

  localparam int unsigned BYTE_W   = 8;
  localparam int unsigned STATUS_W = 32;
  localparam int unsigned COUNT_W  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } UartTxState_t;

  // status_word bit positions
  localparam int unsigned ACK       = 8;
  localparam int unsigned FULL      = 9;
  localparam int unsigned EMPTY     = 10;
  localparam int unsigned ACTIVE    = 11;
  localparam int unsigned OVERFLOW  = 12;
  localparam int unsigned COUNT_LSB = 16;

endpackage

// File: rtl/mmio_tx_fifo.sv
// Byte FIFO feeding the UART shifter. pop_data shows the head entry
// combinationally so the shifter can load it on the pop edge.
// Ports:
//   clock, reset (async, active-low)
//   push, push_data : write request and byte
//   pop             : remove head entry
//   pop_data        : head entry
//   full, empty     : occupancy flags
//   count           : number of stored entries (0..DEPTH)
module mmio_tx_fifo
  import mmio_uart_tx_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [BYTE_W-1:0]        push_data,
  input  logic                     pop,
  output logic [BYTE_W-1:0]        pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [BYTE_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign pop_data = mem[rd_ptr];

  // A push into a full FIFO is legal only when the head leaves the same edge.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Storage: no reset needed, validity is tracked by count.
  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// MMIO-driven UART transmitter (8N1, LSB first) with a transmit FIFO.
// Ports:
//   clock, reset (async, active-low)
//   command_word : [7:0] byte, [8] send toggle, [9] overflow-clear toggle
//   status_word  : ack/full/empty/active/overflow flags and FIFO count
//   tx           : serial line, idle high
//   busy         : transmitter active or bytes still queued
module mmio_uart_tx
  import mmio_uart_tx_pkg::*;
#(
  parameter int unsigned CLOCKS_PER_BIT = 434,
  parameter int unsigned FIFO_DEPTH     = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [31:0]         command_word,
  output logic [STATUS_W-1:0] status_word,
  output logic                tx,
  output logic                busy
);

  localparam int unsigned BAUD_W = $clog2(CLOCKS_PER_BIT);
  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLOCKS_PER_BIT - 1);

  UartTxState_t      state;
  logic [BAUD_W-1:0] baud;
  logic [2:0]        bit_idx;
  logic [BYTE_W-1:0] shifter;
  logic              prev_send;
  logic              prev_clear;
  logic              overflow;

  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic [BYTE_W-1:0] fifo_data;

  logic              send_req_c;
  logic              clear_req_c;
  logic              bit_end_c;
  logic              pop_c;
  logic              push_c;
  logic              drop_c;
  logic [21:0]       unused_cmd;

  assign unused_cmd = command_word[31:10];

  // Toggle-style handshake: a request is any difference from last cycle.
  assign send_req_c  = command_word[8] ^ prev_send;
  assign clear_req_c = command_word[9] ^ prev_clear;
  assign bit_end_c   = (baud == BAUD_LAST);

  // Pop from IDLE, or at the very end of STOP so frames run back to back.
  assign pop_c  = !fifo_empty && ((state == IDLE) || ((state == STOP) && bit_end_c));
  assign push_c = send_req_c && (!fifo_full || pop_c);
  assign drop_c = send_req_c && !push_c;

  mmio_tx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push_c),
    .push_data (command_word[7:0]),
    .pop       (pop_c),
    .pop_data  (fifo_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Request edge detection and sticky overflow; a drop wins over a clear.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      prev_send  <= 1'b0;
      prev_clear <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      prev_send  <= command_word[8];
      prev_clear <= command_word[9];
      if (drop_c) begin
        overflow <= 1'b1;
      end else if (clear_req_c) begin
        overflow <= 1'b0;
      end
    end
  end

  // Frame FSM; tx is loaded with the level of the state being entered.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      baud    <= '0;
      bit_idx <= '0;
      shifter <= '0;
      tx      <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          baud    <= '0;
          bit_idx <= '0;
          tx      <= 1'b1;
          if (pop_c) begin
            shifter <= fifo_data;
            state   <= START;
            tx      <= 1'b0;
          end
        end
        START: begin
          if (bit_end_c) begin
            baud  <= '0;
            state <= DATA;
            tx    <= shifter[0];
          end else begin
            baud <= baud + BAUD_W'(1);
          end
        end
        DATA: begin
          if (bit_end_c) begin
            baud <= '0;
            if (bit_idx == 3'd7) begin
              bit_idx <= '0;
              state   <= STOP;
              tx      <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              shifter <= shifter >> 1;
              tx      <= shifter[1];
            end
          end else begin
            baud <= baud + BAUD_W'(1);
          end
        end
        STOP: begin
          if (bit_end_c) begin
            baud <= '0;
            if (pop_c) begin
              shifter <= fifo_data;
              state   <= START;
              tx      <= 1'b0;
            end else begin
              state <= IDLE;
              tx    <= 1'b1;
            end
          end else begin
            baud <= baud + BAUD_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

  // Status is assembled purely from registered state.
  always_comb begin
    status_word = '0;
    status_word[ACK]      = prev_send;
    status_word[FULL]     = fifo_full;
    status_word[EMPTY]    = fifo_empty;
    status_word[ACTIVE]   = (state != IDLE);
    status_word[OVERFLOW] = overflow;
    status_word[COUNT_LSB +: COUNT_W] = COUNT_W'(fifo_count);
  end

  assign busy = (state != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx (CLOCKS_PER_BIT=4, FIFO_DEPTH=8).
// A frame-level model predicts FIFO contents, acceptance and line levels;
// a serial receiver decodes tx and checks bytes against a scoreboard queue.
module tb_mmio_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 8;
  localparam int FRAME = 10 * CPB;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] command_word = 32'h0;
  logic [31:0] status_word;
  logic        tx;
  logic        busy;

  always #5 clock = ~clock;

  mmio_uart_tx #(
    .CLOCKS_PER_BIT (CPB),
    .FIFO_DEPTH     (DEPTH)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .command_word (command_word),
    .status_word  (status_word),
    .tx           (tx),
    .busy         (busy)
  );

  int checks   = 0;
  int failures = 0;

  // reference model state
  logic [7:0] m_q[$];
  logic [7:0] exp_q[$];
  int         m_frame_left = 0;
  logic [7:0] m_cur = 8'h00;
  logic       m_prev_send = 1'b0;
  logic       m_prev_clear = 1'b0;
  logic       m_ovf = 1'b0;
  logic       m_s_req, m_c_req, m_pop, m_acc;
  int         cyc = 0;

  // receiver / checker state
  int         start_q[$];
  int         frames_rx = 0;
  int         peak_count = 0;
  logic       mon_active = 1'b0;
  int         mon_cnt = 0;
  logic [7:0] mon_byte = 8'h00;
  logic [31:0] e_status;
  logic        e_tx, e_busy;
  int          k;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    command_word[7:0] = b;
    command_word[8]   = ~command_word[8];
    tick();
  endtask

  task automatic clear_ovf();
    command_word[9] = ~command_word[9];
    tick();
  endtask

  task automatic wait_idle(input int max);
    int n;
    n = 0;
    while ((busy || mon_active || exp_q.size() != 0) && n < max) begin
      tick();
      n++;
    end
    check("drain_timeout", 32'(n < max), 32'd1);
  endtask

  // Model: a frame lasts FRAME cycles after a pop; the next pop can happen on
  // the last edge of a frame or any edge while idle. Pushes see pre-push size.
  initial forever begin
    @(posedge clock);
    cyc++;
    if (!reset) begin
      m_q.delete();
      exp_q.delete();
      m_frame_left = 0;
      m_prev_send  = 1'b0;
      m_prev_clear = 1'b0;
      m_ovf        = 1'b0;
    end else begin
      m_s_req = (command_word[8] != m_prev_send);
      m_c_req = (command_word[9] != m_prev_clear);
      m_pop   = (m_q.size() > 0) && (m_frame_left <= 1);
      m_acc   = m_s_req && ((m_q.size() < DEPTH) || m_pop);
      if (m_pop) begin
        m_cur = m_q.pop_front();
        m_frame_left = FRAME;
      end else if (m_frame_left > 0) begin
        m_frame_left--;
      end
      if (m_acc) begin
        m_q.push_back(command_word[7:0]);
        exp_q.push_back(command_word[7:0]);
      end
      if (m_s_req && !m_acc) m_ovf = 1'b1;
      else if (m_c_req)      m_ovf = 1'b0;
      m_prev_send  = command_word[8];
      m_prev_clear = command_word[9];
    end
  end

  // Per-cycle check of status, line level and busy against the model.
  initial forever begin
    @(negedge clock);
    if (!reset) begin
      e_status = 32'h0000_0400;
      e_tx     = 1'b1;
      e_busy   = 1'b0;
    end else begin
      e_status        = 32'h0;
      e_status[8]     = m_prev_send;
      e_status[9]     = (m_q.size() == DEPTH);
      e_status[10]    = (m_q.size() == 0);
      e_status[11]    = (m_frame_left > 0);
      e_status[12]    = m_ovf;
      e_status[23:16] = 8'(m_q.size());
      e_busy          = (m_frame_left > 0) || (m_q.size() > 0);
      if (m_frame_left == 0) begin
        e_tx = 1'b1;
      end else begin
        k = (FRAME - m_frame_left) / CPB;
        if (k == 0)      e_tx = 1'b0;
        else if (k <= 8) e_tx = m_cur[k-1];
        else             e_tx = 1'b1;
      end
    end
    check("status", status_word, e_status);
    check("tx", 32'(tx), 32'(e_tx));
    check("busy", 32'(busy), 32'(e_busy));
    if (int'(status_word[23:16]) > peak_count) peak_count = int'(status_word[23:16]);
  end

  // Serial receiver: sample each bit mid-way and score the decoded byte.
  initial forever begin
    @(negedge clock);
    if (!reset) begin
      mon_active = 1'b0;
    end else if (!mon_active) begin
      if (tx == 1'b0) begin
        mon_active = 1'b1;
        mon_cnt    = 0;
        start_q.push_back(cyc);
      end
    end else begin
      mon_cnt++;
      if (mon_cnt >= 5 && mon_cnt <= 33 && ((mon_cnt - 5) % CPB) == 0)
        mon_byte[(mon_cnt - 5) / CPB] = tx;
      if (mon_cnt == 37) begin
        mon_active = 1'b0;
        frames_rx++;
        check("stop_bit", 32'(tx), 32'd1);
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_frame: got byte 0x%02h with none expected", mon_byte);
        end else begin
          check("rx_byte", 32'(mon_byte), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    int f0;
    int found;

    // reset state
    repeat (3) @(posedge clock);
    #1;
    check("reset_status", status_word, 32'h0000_0400);
    check("reset_tx", 32'(tx), 32'd1);
    check("reset_busy", 32'(busy), 32'd0);
    reset = 1'b1;
    tick();

    // single byte 0x55: ack after one edge, start bit one edge later
    command_word = 32'h0000_0155;
    tick();
    check("ack_after_edge", 32'(status_word[8]), 32'd1);
    check("tx_before_pop", 32'(tx), 32'd1);
    tick();
    check("tx_start_bit", 32'(tx), 32'd0);
    wait_idle(60);
    check("single_busy_low", 32'(busy), 32'd0);

    // three back-to-back requests: contiguous frames, peak count 2
    start_q.delete();
    peak_count = 0;
    send(8'h01);
    send(8'h02);
    send(8'h03);
    wait_idle(200);
    check("peak_count", 32'(peak_count), 32'd2);
    check("frame_count", 32'(start_q.size()), 32'd3);
    if (start_q.size() == 3) begin
      check("gap_1_2", 32'(start_q[1] - start_q[0]), 32'(FRAME));
      check("gap_2_3", 32'(start_q[2] - start_q[1]), 32'(FRAME));
    end

    // fill while a frame is in flight, overflow, clear, then push-at-pop
    f0 = frames_rx;
    send(8'hA0);
    tick();
    tick();
    for (int i = 0; i < DEPTH; i++) send(8'($urandom_range(0, 255)));
    send(8'hEE);
    send(8'hEF);
    check("full_flag", 32'(status_word[9]), 32'd1);
    check("full_count", 32'(status_word[23:16]), 32'd8);
    check("overflow_set", 32'(status_word[12]), 32'd1);
    clear_ovf();
    check("overflow_cleared", 32'(status_word[12]), 32'd0);
    found = 0;
    for (int i = 0; i < 100; i++) begin
      if (m_frame_left == 1 && m_q.size() == DEPTH) begin
        found = 1;
        break;
      end
      tick();
    end
    check("pop_slot_found", 32'(found), 32'd1);
    send(8'h3C);
    check("push_at_pop_ovf", 32'(status_word[12]), 32'd0);
    check("push_at_pop_count", 32'(status_word[23:16]), 32'd8);
    wait_idle(600);
    check("overflow_frames", 32'(frames_rx - f0), 32'd10);

    // reset in the middle of a data bit of frame 2 of 3
    send(8'h5A);
    send(8'h00);
    send(8'hC3);
    repeat (45) tick();
    #3;
    check("tx_low_before_reset", 32'(tx), 32'd0);
    reset = 1'b0;
    #1;
    check("reset_tx_immediate", 32'(tx), 32'd1);
    check("reset_status_mid", status_word, 32'h0000_0400);
    command_word = 32'h0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b1;
    f0 = frames_rx;
    repeat (100) tick();
    check("no_frames_after_reset", 32'(frames_rx - f0), 32'd0);

    // hold bit 8 steady while the byte field changes
    for (int i = 0; i < 100; i++) begin
      command_word[7:0] = 8'($urandom_range(0, 255));
      tick();
    end
    check("hold_count", 32'(status_word[23:16]), 32'd0);
    check("hold_tx", 32'(tx), 32'd1);

    // random traffic with occasional overflow clears
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        command_word[7:0] = 8'($urandom_range(0, 255));
        command_word[8]   = ~command_word[8];
      end
      if ($urandom_range(0, 19) == 0) command_word[9] = ~command_word[9];
      tick();
    end
    wait_idle(DEPTH * FRAME + 200);

    // release reset with bit 8 already high: counts as a send
    reset = 1'b0;
    command_word = 32'h0000_017E;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    f0 = frames_rx;
    tick();
    check("release_send_count", 32'(status_word[23:16]), 32'd1);
    wait_idle(100);
    check("release_send_frame", 32'(frames_rx - f0), 32'd1);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mmio_uart_tx.md
MMIO_UART_TX -- requirements
Module: mmio_uart_tx

Interface
REQ-001 The block SHALL have parameter CLOCKS_PER_BIT, default 434, meaning clock cycles per serial bit (minimum 2).
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 8, meaning transmit FIFO entries (power of two, 2..256).
REQ-003 The block SHALL have one clock, port clock, input, 1 bit, with all state on its rising edge.
REQ-004 The block SHALL have reset, input, 1 bit; asynchronous, active-low.
REQ-005 The block SHALL have command_word, input, 32 bits, driven by one MMIO output port register: [7:0] data byte, [8] send toggle, [9] overflow-clear toggle, others ignored.
REQ-006 The block SHALL have status_word, output, 32 bits, feeding the matching MMIO input port.
REQ-007 The block SHALL have tx, output, 1 bit, serial line, idle high.
REQ-008 The block SHALL have busy, output, 1 bit: high when the FSM is not IDLE or the FIFO is non-empty.

Function
REQ-009 The block SHALL register command_word[9:8] every cycle as prev_send and prev_clear.
REQ-010 A send request SHALL be command_word[8] != prev_send, and SHALL be evaluated combinationally against the current command_word.
REQ-011 On a send request, the block SHALL push command_word[7:0] at that edge if count < FIFO_DEPTH, or if a pop occurs in the same cycle.
REQ-012 A send request while full with no same-cycle pop SHALL drop the byte and set the sticky overflow flag.
REQ-013 On a clear request (command_word[9] != prev_clear), the block SHALL clear overflow; if a clear and an overflow occur in the same cycle, overflow SHALL end set.
REQ-014 The status_word layout SHALL be:
  - [8] ack: copy of prev_send; each request is accepted or dropped one edge after it is seen.
  - [9] full.
  - [10] empty.
  - [11] FSM not IDLE.
  - [12] overflow.
  - [23:16] FIFO count, zero-extended.
  - All other bits 0.
REQ-015 status_word SHALL be driven from registers only, with no combinational path from command_word.
REQ-016 The FSM states SHALL be IDLE, START, DATA, STOP.
  - IDLE: tx=1; if FIFO non-empty, pop into the shifter and go to START at the next edge.
  - START: tx=0 for CLOCKS_PER_BIT cycles, then DATA.
  - DATA: tx=shifter[0], LSB first, 8 bits of CLOCKS_PER_BIT cycles each, using a 3-bit bit index; then STOP.
  - STOP: tx=1 for CLOCKS_PER_BIT cycles; then, if FIFO non-empty, pop and go directly to START with no idle gap, else go to IDLE.
REQ-017 The baud counter SHALL count 0..CLOCKS_PER_BIT-1, be sized $clog2(CLOCKS_PER_BIT), and wrap to 0 at each bit boundary.
REQ-018 tx SHALL be a registered output.
REQ-019 The first start bit SHALL appear on tx two edges after the request edge (push edge, then pop edge).
REQ-020 FIFO pointers SHALL wrap modulo FIFO_DEPTH.
REQ-021 The FIFO count SHALL stay unchanged on a simultaneous push and pop.
REQ-022 Pushes and pops SHALL never corrupt data at the full or empty boundary.

Reset
REQ-023 While reset is low, the block SHALL force, asynchronously:
  - FSM to IDLE, tx=1, busy=0.
  - FIFO empty (count 0, pointers 0).
  - overflow=0, prev_send=0, prev_clear=0.
  - Baud counter and bit index to 0.
  - status_word = 32'h00000400.
REQ-024 Reset asserted mid-frame SHALL abort the frame, drive tx high immediately, and discard all queued bytes.
REQ-025 After reset release with command_word[8]=1, the block SHALL treat the first cycle as a send request; the MMIO register resets to 0, so this only occurs with a non-reset source.

Structure
REQ-026 The shared package SHALL hold the state enum UartTxState_t and the status bit-index constants (ACK, FULL, EMPTY, ACTIVE, OVERFLOW, COUNT_LSB).
REQ-027 The FIFO SHALL be a separate sub-module mmio_tx_fifo with parameter DEPTH, 8-bit data, push/pop/full/empty/count ports, and the same clock and reset.
REQ-028 No other sub-modules SHALL be used.

Verification
REQ-029 With CLOCKS_PER_BIT=4 and FIFO_DEPTH=8, a bench SHALL drive command_word 0x00000155:
  - status ack=1 after one edge.
  - tx shows start 0, then 1,0,1,0,1,0,1,0, then stop 1, each 4 cycles (40 cycles total).
  - FSM returns to IDLE.
  - busy falls.
REQ-030 A bench SHALL toggle bit 8 three times back-to-back with bytes 0x01, 0x02, 0x03:
  - count peaks at 2.
  - Three frames are sent contiguously with no idle gap between stop and start.
  - Bytes arrive in order.
REQ-031 A bench SHALL fill the FIFO while the FSM is stalled mid-frame, then issue 2 extra requests:
  - full=1, count=8.
  - overflow=1.
  - Only the first 9 bytes (1 in shifter plus 8 queued) are transmitted.
  - Toggling bit 9 clears overflow next edge.
REQ-032 A bench SHALL issue a send request in the same cycle as a pop with the FIFO full:
  - Byte accepted, overflow=0, count stays 8.
REQ-033 A bench SHALL assert reset halfway through a DATA bit of frame 2 of 3:
  - tx=1 immediately.
  - status_word=0x00000400.
  - After release, no further frames are sent.
REQ-034 A bench SHALL hold bit 8 constant for 100 cycles:
  - No pushes, count=0, tx stays 1.
